// File: rtl/glitch_seq.sv
// rtl/glitch_seq.sv - multi-pulse glitch sequencer driving the VCC select switch
module glitch_seq #(
    parameter int DELAY_W        = 16,
    parameter int WIDTH_W        = 8,
    parameter int GAP_W          = 16,
    parameter int MAX_PULSES     = 4,
    parameter int OUT_ACTIVE_LOW = 0,
    localparam int CNT_W         = $clog2(MAX_PULSES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               trig_sel,
    input  logic               trigger,
    input  logic [DELAY_W-1:0] delay_in,
    input  logic [WIDTH_W-1:0] width_in,
    input  logic [GAP_W-1:0]   gap_in,
    input  logic [CNT_W-1:0]   count_in,
    output logic               glitch_out,
    output logic               busy,
    output logic               armed,
    output logic               done
);

    localparam int CW_A = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;
    localparam int CW   = (CW_A > GAP_W) ? CW_A : GAP_W;
    localparam logic INV = (OUT_ACTIVE_LOW != 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               glitch_q, glitch_d;
    logic               done_q, done_d;
    logic [2:0]         sync_q;
    logic               rise;

    // Two synchroniser stages plus an edge flop; runs regardless of state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], trigger};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        delay_d  = delay_q;
        width_d  = width_q;
        gap_d    = gap_q;
        rem_d    = rem_q;
        glitch_d = glitch_q;
        done_d   = 1'b0;
        if (abort) begin
            state_d  = S_IDLE;
            glitch_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm && (count_in != '0)) begin
                        delay_d = delay_in;
                        // Zero width/gap are stored as one cycle so the counters never underflow.
                        width_d = (width_in == '0) ? WIDTH_W'(1) : width_in;
                        gap_d   = (gap_in == '0) ? GAP_W'(1) : gap_in;
                        rem_d   = (count_in > CNT_W'(MAX_PULSES)) ? CNT_W'(MAX_PULSES) : count_in;
                        if (trig_sel) begin
                            state_d = S_DELAY;
                            cnt_d   = CW'(delay_in);
                        end else begin
                            state_d = S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    if (rise) begin
                        state_d = S_DELAY;
                        cnt_d   = CW'(delay_q);
                    end
                end
                S_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d  = S_PULSE;
                        glitch_d = 1'b1;
                        cnt_d    = CW'(width_q) - CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        glitch_d = 1'b0;
                        if (rem_q > CNT_W'(1)) begin
                            state_d = S_GAP;
                            rem_d   = rem_q - CNT_W'(1);
                            cnt_d   = CW'(gap_q) - CW'(1);
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_d  = S_PULSE;
                        glitch_d = 1'b1;
                        cnt_d    = CW'(width_q) - CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    glitch_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            delay_q  <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            rem_q    <= '0;
            glitch_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            rem_q    <= rem_d;
            glitch_q <= glitch_d;
            done_q   <= done_d;
        end
    end

    assign glitch_out = glitch_q ^ INV;
    assign busy       = (state_q != S_IDLE);
    assign armed      = (state_q == S_ARMED);
    assign done       = done_q;

endmodule

// File: tb/tb_glitch_seq.sv
// tb/tb_glitch_seq.sv - scoreboard bench for glitch_seq, both output polarities
module tb_glitch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trig_sel = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] delay_in = '0;
    logic [7:0]  width_in = '0;
    logic [15:0] gap_in = '0;
    logic [2:0]  count_in = '0;
    logic        g_a, busy_a, armed_a, done_a;
    logic        g_b, busy_b, armed_b, done_b;

    glitch_seq dut_a (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_sel(trig_sel),
        .trigger(trigger), .delay_in(delay_in), .width_in(width_in), .gap_in(gap_in),
        .count_in(count_in), .glitch_out(g_a), .busy(busy_a), .armed(armed_a), .done(done_a)
    );

    glitch_seq #(.OUT_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig_sel(trig_sel),
        .trigger(trigger), .delay_in(delay_in), .width_in(width_in), .gap_in(gap_in),
        .count_in(count_in), .glitch_out(g_b), .busy(busy_b), .armed(armed_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    localparam int K_RISE = 0;
    localparam int K_FALL = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        qa.push_back(e);
        qb.push_back(e);
    endtask

    task automatic pop_cmp(input int d, input int kind);
        ev_t e;
        bit  empty;
        checks++;
        empty = (d == 0) ? (qa.size() == 0) : (qb.size() == 0);
        if (empty) begin
            errors++;
            $display("FAIL event_dut%0d: unexpected kind %0d at cycle %0d", d, kind, cyc);
        end else begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_dut%0d: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                         d, kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Reference: pulse i rises at p0 + i*(W'+G'); an abort at edge ab drops everything from ab on.
    task automatic plan_seq(input int s, input int d, input int wp, input int gp, input int nc, input int ab);
        ev_t lst[$];
        ev_t e;
        int  p0;
        bit  live;
        p0 = s + 1 + d;
        for (int i = 0; i < nc; i++) begin
            e.kind = K_RISE; e.cyc = p0 + i * (wp + gp);      lst.push_back(e);
            e.kind = K_FALL; e.cyc = p0 + i * (wp + gp) + wp; lst.push_back(e);
        end
        e.kind = K_DONE; e.cyc = p0 + (nc - 1) * (wp + gp) + wp; lst.push_back(e);
        live = 1'b0;
        foreach (lst[i]) begin
            if (ab < 0 || lst[i].cyc < ab) begin
                push(lst[i].kind, lst[i].cyc);
                if (lst[i].kind == K_RISE) live = 1'b1;
                else if (lst[i].kind == K_FALL) live = 1'b0;
            end
        end
        if (ab >= 0 && live) push(K_FALL, ab);
    endtask

    // ab_off: -1 no abort, 0 random abort, >0 abort at edge a+ab_off.
    task automatic run_imm(input int d, input int w, input int g, input int n, input int ab_off);
        int a, wp, gp, nc, fin, ab;
        wp = (w == 0) ? 1 : w;
        gp = (g == 0) ? 1 : g;
        nc = (n > 4) ? 4 : n;
        @(negedge clk);
        a = cyc + 1;
        delay_in = 16'(d); width_in = 8'(w); gap_in = 16'(g); count_in = 3'(n);
        trig_sel = 1'b1;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        if (nc == 0) begin
            chk("busy_after_n0", busy_a, 0);
            return;
        end
        fin = a + 1 + d + nc * wp + (nc - 1) * gp;
        if (ab_off < 0)       ab = -1;
        else if (ab_off == 0) ab = a + int'($urandom_range(fin - a, 1));
        else                  ab = a + ab_off;
        plan_seq(a, d, wp, gp, nc, ab);
        if (ab >= 0) fin = ab;
        chk("busy_at_arm", busy_a, 1);
        chk("armed_imm", armed_a, 0);
        delay_in = 16'($urandom_range(3, 0)); width_in = 8'($urandom_range(9, 0));
        gap_in = 16'($urandom_range(9, 0)); count_in = 3'($urandom_range(7, 1));
        arm = 1'b1;
        abort = (ab >= 0 && cyc == ab - 1);
        while (cyc < fin) begin
            @(negedge clk);
            arm = 1'b0;
            abort = (ab >= 0 && cyc == ab - 1);
        end
        abort = 1'b0;
        chk("busy_end", busy_a, 0);
        chk("done_end", done_a, (ab >= 0) ? 0 : 1);
        @(negedge clk);
    endtask

    task automatic run_trig(input int d, input int w, input int g, input int n, input int r);
        int k, wp, gp, nc, fin;
        wp = (w == 0) ? 1 : w;
        gp = (g == 0) ? 1 : g;
        nc = (n > 4) ? 4 : n;
        @(negedge clk);
        delay_in = 16'(d); width_in = 8'(w); gap_in = 16'(g); count_in = 3'(n);
        trig_sel = 1'b0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("armed_at_arm", armed_a, 1);
        chk("busy_trig", busy_a, 1);
        repeat (r) @(negedge clk);
        trigger = 1'b1;
        k = cyc + 1;
        plan_seq(k + 2, d, wp, gp, nc, -1);
        fin = k + 3 + d + nc * wp + (nc - 1) * gp;
        while (cyc < fin) @(negedge clk);
        chk("busy_end_trig", busy_a, 0);
        chk("done_end_trig", done_a, 1);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    bit pa = 1'b0;
    bit pb = 1'b0;
    always @(negedge clk) begin
        bit act_a, act_b;
        act_a = g_a;
        act_b = ~g_b;
        if (rst_n) begin
            if (act_a && !pa) pop_cmp(0, K_RISE);
            if (!act_a && pa) pop_cmp(0, K_FALL);
            if (done_a)       pop_cmp(0, K_DONE);
            if (act_b && !pb) pop_cmp(1, K_RISE);
            if (!act_b && pb) pop_cmp(1, K_FALL);
            if (done_b)       pop_cmp(1, K_DONE);
        end
        pa = act_a;
        pb = act_b;
    end

    initial begin
        int k;
        int a;
        // Reset held with trigger toggling.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            trigger = ~trigger;
            if (i == 3) begin
                chk("rst_glitch_a", g_a, 0);
                chk("rst_glitch_b", g_b, 1);
                chk("rst_busy", busy_a | busy_b, 0);
                chk("rst_armed", armed_a | armed_b, 0);
                chk("rst_done", done_a | done_b, 0);
            end
        end
        trigger = 1'b0;
        rst_n = 1'b1;

        // Arm sampled at edge 10: pulses 16-19 and 23-26, done at 26.
        while (cyc < 9) @(negedge clk);
        delay_in = 16'd5; width_in = 8'd3; gap_in = 16'd4; count_in = 3'd2;
        trig_sel = 1'b1;
        arm = 1'b1;
        push(K_RISE, 16); push(K_FALL, 19); push(K_RISE, 23); push(K_FALL, 26); push(K_DONE, 26);
        @(negedge clk);
        arm = 1'b0;
        chk("dir_busy_10", busy_a, 1);
        while (cyc < 25) @(negedge clk);
        chk("dir_busy_25", busy_a, 1);
        @(negedge clk);
        chk("dir_busy_26", busy_a, 0);
        @(negedge clk);

        // Trigger already high at arm must not start the sequence.
        trigger = 1'b1;
        repeat (5) @(negedge clk);
        delay_in = 16'd0; width_in = 8'd1; gap_in = 16'd0; count_in = 3'd1;
        trig_sel = 1'b0;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (10) @(negedge clk);
        chk("stale_trigger_armed", armed_a, 1);
        trigger = 1'b0;
        repeat (3) @(negedge clk);
        trigger = 1'b1;
        k = cyc + 1;
        push(K_RISE, k + 3); push(K_FALL, k + 4); push(K_DONE, k + 4);
        while (cyc < k + 4) @(negedge clk);
        chk("trig_busy_end", busy_a, 0);
        trigger = 1'b0;
        repeat (3) @(negedge clk);

        // Clamps and ignored zero-count arm.
        run_imm(2, 0, 0, 7, -1);
        run_imm(3, 2, 2, 0, -1);

        // Abort during the second of three pulses (rises at a+8).
        run_imm(1, 4, 2, 3, 9);

        // Abort together with arm in IDLE.
        @(negedge clk);
        count_in = 3'd1; trig_sel = 1'b1; arm = 1'b1; abort = 1'b1;
        @(negedge clk);
        arm = 1'b0; abort = 1'b0;
        chk("abort_arm_idle", busy_a, 0);
        repeat (8) @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            int d, w, g, n;
            d = $urandom_range(12, 0);
            w = $urandom_range(4, 0);
            g = $urandom_range(4, 0);
            n = $urandom_range(7, 0);
            if ($urandom_range(1, 0) == 1)
                run_imm(d, w, g, n, ($urandom_range(3, 0) == 0) ? 0 : -1);
            else
                run_trig(d, w, g, (n == 0) ? 1 : n, $urandom_range(4, 1));
        end

        // Asynchronous reset in the middle of a long pulse.
        @(negedge clk);
        delay_in = 16'd0; width_in = 8'd20; gap_in = 16'd1; count_in = 3'd1;
        trig_sel = 1'b1;
        arm = 1'b1;
        a = cyc + 1;
        plan_seq(a, 0, 20, 1, 1, -1);
        @(negedge clk);
        arm = 1'b0;
        while (cyc < a + 4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_glitch_a", g_a, 0);
        chk("async_rst_glitch_b", g_b, 1);
        chk("async_rst_busy", busy_a, 0);
        qa.delete();
        qb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("pending_events_a", qa.size(), 0);
        chk("pending_events_b", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glitch_seq.md
# glitch_seq

Parametrised multi-pulse glitch sequencer for the voltage-glitch path. It replaces the single-shot delay-then-pulse chain with one block that drives `vcc_select`. It latches a delay, a pulse width, an inter-pulse gap and a pulse count on `arm`. It then starts either immediately or on a synchronised rising edge of an external trigger, and emits a train of up to `MAX_PULSES` glitch pulses. Control comes from the UART command parser; the output drives the VCC select switch.

## Interface
- `DELAY_W`, 16: width of delay count (clock cycles).
- `WIDTH_W`, 8: width of pulse-width count.
- `GAP_W`, 16: width of inter-pulse gap count.
- `MAX_PULSES`, 4: maximum pulses per sequence; `CNT_W = $clog2(MAX_PULSES+1)`.
- `OUT_ACTIVE_LOW`, 0: 1 inverts `glitch_out` (inactive level = 1).

Ports:
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `arm`, in, 1: start request, sampled in IDLE only.
- `abort`, in, 1: synchronous cancel, any state.
- `trig_sel`, in, 1: 0 = start on external trigger edge, 1 = start immediately on arm.
- `trigger`, in, 1: asynchronous external trigger (e.g. target reset release, target UART line).
- `delay_in`, in, `DELAY_W`: cycles from start to first pulse.
- `width_in`, in, `WIDTH_W`: pulse high cycles.
- `gap_in`, in, `GAP_W`: low cycles between pulses.
- `count_in`, in, `CNT_W`: pulses in sequence.
- `glitch_out`, out, 1: registered glitch drive.
- `busy`, out, 1: state ≠ IDLE.
- `armed`, out, 1: state = ARMED (waiting for trigger).
- `done`, out, 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, ARMED, DELAY, PULSE, GAP. All outputs registered.
- Reset: state IDLE, counters 0, `glitch_out` inactive, `busy`/`armed`/`done` 0.
- IDLE + `arm` + `count_in`≠0: latch `delay_in`, `width_in`, `gap_in`, `count_in` and `trig_sel`. Go to ARMED (`trig_sel`=0) or DELAY (`trig_sel`=1).
- IDLE + `arm` + `count_in`=0: ignored, no `done`.
- Count clamp: latched count = min(`count_in`, `MAX_PULSES`).
- Zero-value clamps: effective width W' = max(W,1); effective gap G' = max(G,1). Delay 0 is legal.
- Trigger path: 2-flop synchroniser plus one edge flop; rise = s2 & ~s3. The detector runs continuously, but a rise is acted on only in ARMED. A trigger already high at arm time does not start; the next rising edge is required.
- ARMED + rise → DELAY, counter loaded with D.
- DELAY: counter at 0 → PULSE (`glitch_out` active); else decrement.
- PULSE: lasts W' cycles, then one of:
  - remaining pulses > 1 → GAP;
  - otherwise → IDLE with `done`=1 for one cycle.
- GAP: lasts G' cycles → PULSE; the remaining-pulse counter decrements per completed pulse.
- `arm` while `busy`: ignored; latched config is unaffected by input changes.
- `abort`: at the next edge → IDLE, `glitch_out` inactive, no `done`. Abort wins over simultaneous `arm` or any transition.
- `rst_n` low mid-sequence: immediate return to reset values; `glitch_out` inactive asynchronously.

## Timing
- Immediate mode: `arm` sampled at edge a → `busy` at a. `glitch_out` active from edge a+1+D.
- Trigger mode:
  - `arm` at edge a → `armed` at a.
  - `trigger` first sampled high at edge k (k>a) → DELAY at k+2.
  - `glitch_out` active from edge k+3+D.
  - Jitter vs asynchronous trigger: ≤1 cycle.
- Pulse i (0-based) rises at p0 + i·(W'+G') and falls W' edges after its rise.
- After the last fall at edge f: `done`=1 for cycle f..f+1; `busy`=0 at f.
- A new `arm` is accepted at f+1.
- Total sequence length from first rise: N·W' + (N−1)·G' cycles.

## Test plan
- Reset: hold `rst_n`=0 with `trigger` toggling → `glitch_out` inactive, `busy`=`armed`=`done`=0.
- Immediate mode, D=5, W=3, G=4, N=2, arm at edge 10 → `glitch_out` high edges 16–19 and 23–26, `done` asserted at edge 26, `busy` falls at 26.
- Trigger mode, D=0, W=1, N=1:
  - `trigger` high before arm → no pulse, `armed` stays 1;
  - drop `trigger`, then raise it (sampled at edge k) → single 1-cycle pulse from edge k+3.
- Clamps: W=0, G=0, N=7 with `MAX_PULSES`=4 → 4 one-cycle pulses separated by 1-cycle gaps; N=0 → arm ignored.
- Abort mid-PULSE of pulse 2 of 3 → `glitch_out` inactive next edge, no `done`, IDLE. Abort and arm in the same cycle in IDLE → remains IDLE.
- `OUT_ACTIVE_LOW`=1 rerun of the immediate-mode case → output inverted; reset level 1.
